// File: rtl/decode_operand_stage_if.sv
// -----------------------------------------------------------------------------
// decode_operand_stage_if
//   Bundles the decode-side inputs, register-file read port, write-back mirror,
//   pipeline control and ID/EX outputs of decode_operand_stage.
//
//   modport slave  : the decode/operand stage itself (consumes i_*, drives o_*)
//   modport master : whoever drives the stage (IF/ID, register file, WB, hazard
//                    control, or a testbench)
//
//   Parameters: NB_ADDR register address width, NB_DATA datapath width,
//               NB_CTRL opaque control bundle width, NB_CNT bubble counter width.
// -----------------------------------------------------------------------------
interface decode_operand_stage_if #(
    parameter int NB_ADDR = 5,
    parameter int NB_DATA = 32,
    parameter int NB_CTRL = 16,
    parameter int NB_CNT  = 16
);
    // Decoded instruction from IF/ID
    logic               i_if_valid;
    logic [NB_ADDR-1:0] i_rs_addr;
    logic [NB_ADDR-1:0] i_rt_addr;
    logic [NB_ADDR-1:0] i_rd_addr;
    logic               i_uses_rs;
    logic               i_uses_rt;
    logic               i_mem_read;
    logic               i_reg_write;
    logic [NB_DATA-1:0] i_imm;
    logic [NB_CTRL-1:0] i_ctrl;

    // Register-file read port
    logic [NB_ADDR-1:0] o_rf_read_addr_a;
    logic [NB_ADDR-1:0] o_rf_read_addr_b;
    logic [NB_DATA-1:0] i_rf_data_a;
    logic [NB_DATA-1:0] i_rf_data_b;

    // Mirror of the register-file write port
    logic               i_wb_write_enable;
    logic [NB_ADDR-1:0] i_wb_write_addr;
    logic [NB_DATA-1:0] i_wb_data;

    // Pipeline control
    logic               i_stall;
    logic               i_flush;
    logic               o_stall_fetch;

    // ID/EX register
    logic               o_ex_valid;
    logic [NB_DATA-1:0] o_ex_data_a;
    logic [NB_DATA-1:0] o_ex_data_b;
    logic [NB_DATA-1:0] o_ex_imm;
    logic [NB_ADDR-1:0] o_ex_rs_addr;
    logic [NB_ADDR-1:0] o_ex_rt_addr;
    logic [NB_ADDR-1:0] o_ex_rd_addr;
    logic               o_ex_mem_read;
    logic               o_ex_reg_write;
    logic [NB_CTRL-1:0] o_ex_ctrl;
    logic [NB_CNT-1:0]  o_bubble_count;

    modport slave (
        input  i_if_valid, i_rs_addr, i_rt_addr, i_rd_addr, i_uses_rs, i_uses_rt,
               i_mem_read, i_reg_write, i_imm, i_ctrl,
               i_rf_data_a, i_rf_data_b,
               i_wb_write_enable, i_wb_write_addr, i_wb_data,
               i_stall, i_flush,
        output o_rf_read_addr_a, o_rf_read_addr_b, o_stall_fetch,
               o_ex_valid, o_ex_data_a, o_ex_data_b, o_ex_imm,
               o_ex_rs_addr, o_ex_rt_addr, o_ex_rd_addr,
               o_ex_mem_read, o_ex_reg_write, o_ex_ctrl, o_bubble_count
    );

    modport master (
        output i_if_valid, i_rs_addr, i_rt_addr, i_rd_addr, i_uses_rs, i_uses_rt,
               i_mem_read, i_reg_write, i_imm, i_ctrl,
               i_rf_data_a, i_rf_data_b,
               i_wb_write_enable, i_wb_write_addr, i_wb_data,
               i_stall, i_flush,
        input  o_rf_read_addr_a, o_rf_read_addr_b, o_stall_fetch,
               o_ex_valid, o_ex_data_a, o_ex_data_b, o_ex_imm,
               o_ex_rs_addr, o_ex_rt_addr, o_ex_rd_addr,
               o_ex_mem_read, o_ex_reg_write, o_ex_ctrl, o_bubble_count
    );
endinterface

// File: rtl/decode_operand_stage.sv
// -----------------------------------------------------------------------------
// decode_operand_stage
//   Decode-to-execute boundary of the pipelined core:
//     - drives the register-file read addresses and reads operands back,
//     - bypasses a same-cycle write-back onto the operands,
//     - detects load-use hazards and inserts one bubble per hazard,
//     - holds the ID/EX pipeline register with stall, flush and valid handling.
//
//   Ports:
//     i_clock    rising-edge clock
//     i_reset_n  asynchronous active-low reset
//     bus        decode_operand_stage_if.slave (decode inputs, RF read port,
//                WB mirror, stall/flush, ID/EX outputs, bubble counter)
//
//   Optional feature macro: DECODE_ZERO_REG_EN
//     defined   -> register 0 reads as zero, is never bypassed/refreshed and
//                  never causes a load-use hazard
//     undefined -> register 0 is an ordinary register
// -----------------------------------------------------------------------------
module decode_operand_stage #(
    parameter int NB_ADDR = 5,
    parameter int NB_DATA = 32,
    parameter int NB_CTRL = 16,
    parameter int NB_CNT  = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    decode_operand_stage_if.slave  bus
);

`ifdef DECODE_ZERO_REG_EN
    localparam bit ZERO_REG_EN = 1'b1;
`else
    localparam bit ZERO_REG_EN = 1'b0;
`endif

    typedef struct packed {
        logic               valid;
        logic [NB_DATA-1:0] data_a;
        logic [NB_DATA-1:0] data_b;
        logic [NB_DATA-1:0] imm;
        logic [NB_ADDR-1:0] rs_addr;
        logic [NB_ADDR-1:0] rt_addr;
        logic [NB_ADDR-1:0] rd_addr;
        logic               mem_read;
        logic               reg_write;
        logic [NB_CTRL-1:0] ctrl;
    } ex_t;

    ex_t               ex_q, ex_d;
    logic [NB_CNT-1:0] bubble_cnt_q, bubble_cnt_d;

    // True when addr is the hard-wired zero register (only with the feature on).
    function automatic logic is_zero_reg(input logic [NB_ADDR-1:0] addr);
        return ZERO_REG_EN && (addr == '0);
    endfunction

    // A write-back that may be forwarded: enabled and not aimed at register 0
    // when that register is hard-wired.
    logic wb_usable;
    assign wb_usable = bus.i_wb_write_enable && !is_zero_reg(bus.i_wb_write_addr);

    // ---------------------------------------------------------------- operands
    assign bus.o_rf_read_addr_a = bus.i_rs_addr;
    assign bus.o_rf_read_addr_b = bus.i_rt_addr;

    logic [NB_DATA-1:0] op_a, op_b;

    always_comb begin
        if (is_zero_reg(bus.i_rs_addr))
            op_a = '0;
        else if (wb_usable && bus.i_wb_write_addr == bus.i_rs_addr)
            op_a = bus.i_wb_data;
        else
            op_a = bus.i_rf_data_a;

        if (is_zero_reg(bus.i_rt_addr))
            op_b = '0;
        else if (wb_usable && bus.i_wb_write_addr == bus.i_rt_addr)
            op_b = bus.i_wb_data;
        else
            op_b = bus.i_rf_data_b;
    end

    // ---------------------------------------------------------------- hazard
    // A load sitting in EX whose result the decoded instruction needs now.
    // Built only from registered state, so reset clears it without a clock.
    logic load_in_ex, rd_needed, haz;

    assign load_in_ex = ex_q.valid && ex_q.mem_read && ex_q.reg_write
                        && !is_zero_reg(ex_q.rd_addr);
    assign rd_needed  = (bus.i_uses_rs && bus.i_rs_addr == ex_q.rd_addr)
                     || (bus.i_uses_rt && bus.i_rt_addr == ex_q.rd_addr);
    assign haz        = bus.i_if_valid && load_in_ex && rd_needed;

    assign bus.o_stall_fetch = haz && !bus.i_flush;

    // ---------------------------------------------------------------- next state
    // NOTE: every target gets a default first (hold), so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        ex_d         = ex_q;
        bubble_cnt_d = bubble_cnt_q;

        if (bus.i_flush) begin
            ex_d.valid     = 1'b0;
            ex_d.mem_read  = 1'b0;
            ex_d.reg_write = 1'b0;
            ex_d.ctrl      = '0;
        end else if (bus.i_stall) begin
            // Held operands must not go stale while a WB lands on their source.
            if (wb_usable && bus.i_wb_write_addr == ex_q.rs_addr)
                ex_d.data_a = bus.i_wb_data;
            if (wb_usable && bus.i_wb_write_addr == ex_q.rt_addr)
                ex_d.data_b = bus.i_wb_data;
        end else if (haz) begin
            ex_d.valid     = 1'b0;
            ex_d.mem_read  = 1'b0;
            ex_d.reg_write = 1'b0;
            ex_d.ctrl      = '0;
            if (bubble_cnt_q != '1)
                bubble_cnt_d = bubble_cnt_q + NB_CNT'(1);
        end else begin
            ex_d.valid     = bus.i_if_valid;
            ex_d.data_a    = op_a;
            ex_d.data_b    = op_b;
            ex_d.imm       = bus.i_imm;
            ex_d.rs_addr   = bus.i_rs_addr;
            ex_d.rt_addr   = bus.i_rt_addr;
            ex_d.rd_addr   = bus.i_rd_addr;
            ex_d.mem_read  = bus.i_if_valid && bus.i_mem_read;
            ex_d.reg_write = bus.i_if_valid && bus.i_reg_write;
            ex_d.ctrl      = bus.i_if_valid ? bus.i_ctrl : '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ex_q         <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.o_ex_valid     = ex_q.valid;
    assign bus.o_ex_data_a    = ex_q.data_a;
    assign bus.o_ex_data_b    = ex_q.data_b;
    assign bus.o_ex_imm       = ex_q.imm;
    assign bus.o_ex_rs_addr   = ex_q.rs_addr;
    assign bus.o_ex_rt_addr   = ex_q.rt_addr;
    assign bus.o_ex_rd_addr   = ex_q.rd_addr;
    assign bus.o_ex_mem_read  = ex_q.mem_read;
    assign bus.o_ex_reg_write = ex_q.reg_write;
    assign bus.o_ex_ctrl      = ex_q.ctrl;
    assign bus.o_bubble_count = bubble_cnt_q;

endmodule

// File: tb/tb_decode_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_operand_stage
//   Self-checking bench for decode_operand_stage: bypass vector table,
//   hand-written multi-cycle sequences (load-use, flush vs stall, stall
//   refresh, zero register, async reset) and randomized traffic compared
//   against a behavioural model of the ID/EX slot.
//   Honours DECODE_ZERO_REG_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_decode_operand_stage;

    localparam int NB_ADDR = 5;
    localparam int NB_DATA = 32;
    localparam int NB_CTRL = 16;
    localparam int NB_CNT  = 16;

`ifdef DECODE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decode_operand_stage_if #(
        .NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA), .NB_CTRL(NB_CTRL), .NB_CNT(NB_CNT)
    ) bus ();

    decode_operand_stage #(
        .NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA), .NB_CTRL(NB_CTRL), .NB_CNT(NB_CNT)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------ reference model
    // What the EX slot should hold: the instruction last accepted plus the
    // number of bubbles inserted so far.
    typedef struct {
        bit          valid;
        logic [31:0] a, b, imm;
        logic [4:0]  rs, rt, rd;
        bit          mr, rw;
        logic [15:0] ctrl;
    } ex_model_t;

    ex_model_t m;
    int        m_cnt;

    task automatic model_reset();
        m     = '{valid: 0, a: 0, b: 0, imm: 0, rs: 0, rt: 0, rd: 0, mr: 0, rw: 0, ctrl: 0};
        m_cnt = 0;
    endtask

    function automatic bit wb_counts();
        return bus.i_wb_write_enable && !(ZR && bus.i_wb_write_addr == 0);
    endfunction

    // Value a source register really has this cycle.
    function automatic logic [31:0] reg_value(input logic [4:0] addr, input logic [31:0] rf);
        if (ZR && addr == 0)                        return 32'h0;
        if (wb_counts() && bus.i_wb_write_addr == addr) return bus.i_wb_data;
        return rf;
    endfunction

    // Decoded instruction needs a register a load in EX has not yet produced.
    function automatic bit load_use();
        bit pending;
        bit needs;
        pending = m.valid && m.mr && m.rw && !(ZR && m.rd == 0);
        needs   = (bus.i_uses_rs && bus.i_rs_addr == m.rd)
               || (bus.i_uses_rt && bus.i_rt_addr == m.rd);
        return bus.i_if_valid && pending && needs;
    endfunction

    task automatic compare_outputs();
        check("ex_valid",     32'(bus.o_ex_valid),     32'(m.valid));
        check("ex_mem_read",  32'(bus.o_ex_mem_read),  32'(m.mr));
        check("ex_reg_write", 32'(bus.o_ex_reg_write), 32'(m.rw));
        check("ex_ctrl",      32'(bus.o_ex_ctrl),      32'(m.ctrl));
        check("bubble_count", 32'(bus.o_bubble_count), 32'(m_cnt));
        if (m.valid) begin
            check("ex_data_a",  bus.o_ex_data_a,        m.a);
            check("ex_data_b",  bus.o_ex_data_b,        m.b);
            check("ex_imm",     bus.o_ex_imm,           m.imm);
            check("ex_rs_addr", 32'(bus.o_ex_rs_addr),  32'(m.rs));
            check("ex_rt_addr", 32'(bus.o_ex_rt_addr),  32'(m.rt));
            check("ex_rd_addr", 32'(bus.o_ex_rd_addr),  32'(m.rd));
        end
    endtask

    // Called at posedge+1 after inputs are driven: checks combinational
    // outputs mid-cycle, advances the model across the edge, checks the EX slot.
    task automatic cycle();
        ex_model_t nx;
        int        ncnt;
        bit        h;
        #3;
        h = load_use();
        check("stall_fetch", 32'(bus.o_stall_fetch),   32'(h && !bus.i_flush));
        check("rf_addr_a",   32'(bus.o_rf_read_addr_a), 32'(bus.i_rs_addr));
        check("rf_addr_b",   32'(bus.o_rf_read_addr_b), 32'(bus.i_rt_addr));
        nx   = m;
        ncnt = m_cnt;
        if (bus.i_flush) begin
            nx.valid = 0; nx.mr = 0; nx.rw = 0; nx.ctrl = 0;
        end else if (bus.i_stall) begin
            if (wb_counts() && bus.i_wb_write_addr == m.rs) nx.a = bus.i_wb_data;
            if (wb_counts() && bus.i_wb_write_addr == m.rt) nx.b = bus.i_wb_data;
        end else if (h) begin
            nx.valid = 0; nx.mr = 0; nx.rw = 0; nx.ctrl = 0;
            if (ncnt < (1 << NB_CNT) - 1) ncnt++;
        end else begin
            nx.valid = bus.i_if_valid;
            nx.a     = reg_value(bus.i_rs_addr, bus.i_rf_data_a);
            nx.b     = reg_value(bus.i_rt_addr, bus.i_rf_data_b);
            nx.imm   = bus.i_imm;
            nx.rs    = bus.i_rs_addr;
            nx.rt    = bus.i_rt_addr;
            nx.rd    = bus.i_rd_addr;
            nx.mr    = bus.i_if_valid && bus.i_mem_read;
            nx.rw    = bus.i_if_valid && bus.i_reg_write;
            nx.ctrl  = bus.i_if_valid ? bus.i_ctrl : 16'h0;
        end
        @(posedge clk);
        #1;
        m     = nx;
        m_cnt = ncnt;
        compare_outputs();
    endtask

    // ------------------------------------------------------------ stimulus helpers
    task automatic idle();
        bus.i_if_valid = 0; bus.i_rs_addr = 0; bus.i_rt_addr = 0; bus.i_rd_addr = 0;
        bus.i_uses_rs = 0; bus.i_uses_rt = 0; bus.i_mem_read = 0; bus.i_reg_write = 0;
        bus.i_imm = 0; bus.i_ctrl = 0; bus.i_rf_data_a = 0; bus.i_rf_data_b = 0;
        bus.i_wb_write_enable = 0; bus.i_wb_write_addr = 0; bus.i_wb_data = 0;
        bus.i_stall = 0; bus.i_flush = 0;
    endtask

    task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input bit urs, input bit urt, input bit mr, input bit rw,
                         input logic [31:0] imm, input logic [15:0] ctrl);
        bus.i_if_valid = 1; bus.i_rs_addr = rs; bus.i_rt_addr = rt; bus.i_rd_addr = rd;
        bus.i_uses_rs = urs; bus.i_uses_rt = urt; bus.i_mem_read = mr; bus.i_reg_write = rw;
        bus.i_imm = imm; bus.i_ctrl = ctrl;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},  32'(bus.o_ex_valid),     32'h0);
        check({tag, "_data_a"}, bus.o_ex_data_a,          32'h0);
        check({tag, "_data_b"}, bus.o_ex_data_b,          32'h0);
        check({tag, "_imm"},    bus.o_ex_imm,             32'h0);
        check({tag, "_rs"},     32'(bus.o_ex_rs_addr),   32'h0);
        check({tag, "_rt"},     32'(bus.o_ex_rt_addr),   32'h0);
        check({tag, "_rd"},     32'(bus.o_ex_rd_addr),   32'h0);
        check({tag, "_mr"},     32'(bus.o_ex_mem_read),  32'h0);
        check({tag, "_rw"},     32'(bus.o_ex_reg_write), 32'h0);
        check({tag, "_ctrl"},   32'(bus.o_ex_ctrl),      32'h0);
        check({tag, "_count"},  32'(bus.o_bubble_count), 32'h0);
        check({tag, "_stall"},  32'(bus.o_stall_fetch),  32'h0);
    endtask

    // ------------------------------------------------------------ bypass table
    typedef struct {
        logic [4:0]  rs, rt;
        logic [31:0] rf_a, rf_b;
        bit          wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic [31:0] exp_a, exp_b;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{5, 6, 32'h11, 32'h22, 1, 5, 32'hDEAD, 32'hDEAD, 32'h22};
        vecs[1] = '{5, 6, 32'h11, 32'h22, 1, 6, 32'hDEAD, 32'h11,   32'hDEAD};
        vecs[2] = '{5, 6, 32'h11, 32'h22, 0, 5, 32'hDEAD, 32'h11,   32'h22};
        vecs[3] = '{7, 7, 32'h33, 32'h44, 1, 7, 32'hBEEF, 32'hBEEF, 32'hBEEF};
        vecs[4] = '{0, 1, 32'h77, 32'h88, 1, 0, 32'hFF,   ZR ? 32'h0 : 32'hFF, 32'h88};
        vecs[5] = '{0, 0, 32'h77, 32'h66, 0, 0, 32'h0,    ZR ? 32'h0 : 32'h77, ZR ? 32'h0 : 32'h66};

        // ---------------- reset state
        rst_n = 0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1;

        // ---------------- bypass vectors (no loads, so no hazards)
        for (int i = 0; i < 6; i++) begin
            instr(vecs[i].rs, vecs[i].rt, 5'd1, 0, 0, 0, 1, 32'(i), 16'h1);
            bus.i_rf_data_a       = vecs[i].rf_a;
            bus.i_rf_data_b       = vecs[i].rf_b;
            bus.i_wb_write_enable = vecs[i].wb_en;
            bus.i_wb_write_addr   = vecs[i].wb_addr;
            bus.i_wb_data         = vecs[i].wb_data;
            cycle();
            check($sformatf("vec%0d_data_a", i), bus.o_ex_data_a, vecs[i].exp_a);
            check($sformatf("vec%0d_data_b", i), bus.o_ex_data_b, vecs[i].exp_b);
        end
        idle();

        // ---------------- load-use: lw r3 then add using r3
        instr(5'd1, 5'd2, 5'd3, 1, 0, 1, 1, 32'h4, 16'h2);
        cycle();
        instr(5'd3, 5'd4, 5'd4, 1, 1, 0, 1, 32'h0, 16'h3);
        #1;
        check("lu_stall_fetch", 32'(bus.o_stall_fetch), 32'h1);
        cycle();
        check("lu_bubble_valid", 32'(bus.o_ex_valid),     32'h0);
        check("lu_bubble_count", 32'(bus.o_bubble_count), 32'h1);
        #1;
        check("lu_stall_release", 32'(bus.o_stall_fetch), 32'h0);
        cycle();
        check("lu_capture_valid", 32'(bus.o_ex_valid),   32'h1);
        check("lu_capture_rs",    32'(bus.o_ex_rs_addr), 32'h3);
        idle();

        // ---------------- flush beats stall
        instr(5'd1, 5'd2, 5'd7, 0, 0, 1, 1, 32'h8, 16'hABCD);
        cycle();
        instr(5'd7, 5'd2, 5'd5, 1, 0, 0, 1, 32'h0, 16'h5);
        bus.i_stall = 1;
        bus.i_flush = 1;
        cycle();
        check("flush_valid", 32'(bus.o_ex_valid), 32'h0);
        check("flush_ctrl",  32'(bus.o_ex_ctrl),  32'h0);
        idle();

        // ---------------- stall refresh of held rt operand
        instr(5'd8, 5'd9, 5'd10, 1, 1, 0, 1, 32'h55, 16'h12);
        bus.i_rf_data_a = 32'hAAAA;
        bus.i_rf_data_b = 32'hBBBB;
        cycle();
        instr(5'd1, 5'd2, 5'd3, 1, 1, 0, 1, 32'h99, 16'h77);
        bus.i_rf_data_a       = 32'h5;
        bus.i_rf_data_b       = 32'h6;
        bus.i_stall           = 1;
        bus.i_wb_write_enable = 1;
        bus.i_wb_write_addr   = 5'd9;
        bus.i_wb_data         = 32'h1234;
        cycle();
        check("refresh_data_b", bus.o_ex_data_b,          32'h1234);
        check("refresh_data_a", bus.o_ex_data_a,          32'hAAAA);
        check("refresh_rt",     32'(bus.o_ex_rt_addr),   32'h9);
        check("refresh_imm",    bus.o_ex_imm,             32'h55);
        check("refresh_ctrl",   32'(bus.o_ex_ctrl),      32'h12);
        idle();

        // ---------------- load into r0 followed by a use of r0
        instr(5'd1, 5'd2, 5'd0, 0, 0, 1, 1, 32'h0, 16'h1);
        cycle();
        instr(5'd0, 5'd2, 5'd4, 1, 0, 0, 1, 32'h0, 16'h1);
        #1;
        check("r0_load_use_stall", 32'(bus.o_stall_fetch), ZR ? 32'h0 : 32'h1);
        cycle();
        cycle();
        idle();

        // ---------------- asynchronous reset mid-hazard
        instr(5'd1, 5'd3, 5'd2, 0, 0, 1, 1, 32'h42, 16'hF0F0);
        bus.i_rf_data_a = 32'hCAFE;
        cycle();
        instr(5'd4, 5'd2, 5'd6, 0, 1, 0, 1, 32'h0, 16'h1);
        #1;
        check("pre_reset_stall", 32'(bus.o_stall_fetch), 32'h1);
        rst_n = 0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        idle();

        // ---------------- randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            bus.i_if_valid        = ($urandom_range(0, 9) < 8);
            bus.i_rs_addr         = 5'($urandom_range(0, 3));
            bus.i_rt_addr         = 5'($urandom_range(0, 3));
            bus.i_rd_addr         = 5'($urandom_range(0, 3));
            bus.i_uses_rs         = ($urandom_range(0, 9) < 6);
            bus.i_uses_rt         = ($urandom_range(0, 9) < 6);
            bus.i_mem_read        = ($urandom_range(0, 9) < 4);
            bus.i_reg_write       = ($urandom_range(0, 9) < 7);
            bus.i_imm             = $urandom;
            bus.i_ctrl            = 16'($urandom);
            bus.i_rf_data_a       = $urandom;
            bus.i_rf_data_b       = $urandom;
            bus.i_wb_write_enable = ($urandom_range(0, 1) == 1);
            bus.i_wb_write_addr   = 5'($urandom_range(0, 3));
            bus.i_wb_data         = $urandom;
            bus.i_stall           = ($urandom_range(0, 99) < 15);
            bus.i_flush           = ($urandom_range(0, 99) < 10);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decode_operand_stage.md
Name: decode_operand_stage

Overview:
- Decode-to-execute boundary of the pipelined core. Drives the register-file read addresses and consumes the register file's combinational read data.
- Applies write-back bypass for same-cycle RF write/read collisions and detects load-use hazards. Inserts one bubble per hazard.
- Holds the ID/EX pipeline register (operands, immediate, control) with stall, flush and valid handling.

Parameters:
- NB_ADDR, 5, register address width
- NB_DATA, 32, datapath width
- NB_CTRL, 16, opaque execute/memory/write-back control bundle width
- NB_CNT, 16, width of the hazard-bubble counter

Ports:
- i_clock  in  1  rising-edge clock
- i_reset_n  in  1  asynchronous active-low reset
- i_if_valid  in  1  IF/ID holds a valid instruction
- i_rs_addr / i_rt_addr / i_rd_addr  in  NB_ADDR  source A, source B, destination
- i_uses_rs / i_uses_rt  in  1  instruction actually reads rs / rt
- i_mem_read / i_reg_write  in  1  instruction is a load / writes a register
- i_imm  in  NB_DATA  sign-extended immediate
- i_ctrl  in  NB_CTRL  remaining control bits
- o_rf_read_addr_a / o_rf_read_addr_b  out  NB_ADDR  combinational copies of i_rs_addr / i_rt_addr
- i_rf_data_a / i_rf_data_b  in  NB_DATA  register-file read data
- i_wb_write_enable / i_wb_write_addr / i_wb_data  in  1 / NB_ADDR / NB_DATA  mirror of the RF write port
- i_stall  in  1  global hold from downstream
- i_flush  in  1  kill decode slot (branch/jump resolved in EX)
- o_stall_fetch  out  1  freeze PC and IF/ID (load-use)
- o_ex_valid, o_ex_data_a, o_ex_data_b, o_ex_imm, o_ex_rs_addr, o_ex_rt_addr, o_ex_rd_addr, o_ex_mem_read, o_ex_reg_write, o_ex_ctrl  out  registered ID/EX fields
- o_bubble_count  out  NB_CNT  saturating count of inserted bubbles

Behaviour:
- Reset, async on i_reset_n low: all o_ex_* fields and o_bubble_count are 0. o_stall_fetch is 0.
- Bypass, combinational: opA = i_wb_data when i_wb_write_enable is 1 and i_wb_write_addr == i_rs_addr, else i_rf_data_a. opB is the same rule with i_rt_addr and i_rf_data_b.
- Hazard, combinational from registered state: haz = i_if_valid & o_ex_valid & o_ex_mem_read & o_ex_reg_write & ((i_uses_rs & i_rs_addr==o_ex_rd_addr) | (i_uses_rt & i_rt_addr==o_ex_rd_addr)).
  - o_stall_fetch = haz & ~i_flush.
- Each posedge, first match wins:
  1. i_flush: o_ex_valid<=0; o_ex_mem_read, o_ex_reg_write, o_ex_ctrl <=0. Flush overrides i_stall.
  2. i_stall: hold all fields. Exception: if i_wb_write_enable and the write address matches the held o_ex_rs_addr (or o_ex_rt_addr), the matching o_ex_data_a (or o_ex_data_b) is refreshed with i_wb_data.
  3. haz: insert bubble (valid and control zeroed, as in case 1). o_bubble_count increments, saturating at all-ones.
  4. Otherwise capture: o_ex_valid<=i_if_valid, opA/opB, immediate, addresses and control. When i_if_valid is 0, the control outputs capture as 0.
- Latency: one cycle from decode to o_ex_*. One bubble per load-use hazard. After the bubble, o_ex_valid is 0, so haz clears.
- Reset mid-stall or mid-hazard: the stage returns to the empty state immediately, and o_stall_fetch deasserts asynchronously.

Optional Feature:
- Macro: DECODE_ZERO_REG_EN.
- Defined:
  - Address 0 reads as 0, regardless of i_rf_data or bypass.
  - WB writes to address 0 are never bypassed and never refresh held operands.
  - A hazard is never raised when o_ex_rd_addr==0.
- Undefined: address 0 is an ordinary register in bypass, refresh and hazard logic.

Test Plan:
- Reset: assert i_reset_n=0 mid-operation -> all o_ex_* and o_bubble_count are 0 and o_stall_fetch=0 in the same cycle, with no clock edge needed.
- Bypass: decode rs=5 with i_rf_data_a=0x11 while WB writes r5=0xDEAD -> next cycle o_ex_data_a=0xDEAD. With WB address 6, o_ex_data_a=0x11.
- Load-use: lw r3 in EX, decode add uses rs=3 -> o_stall_fetch=1 for one cycle. Next cycle o_ex_valid=0 and o_bubble_count=1. The add is captured the following cycle.
- Flush beats stall: i_stall=1, i_flush=1 with a valid instruction in EX -> o_ex_valid=0 and o_ex_ctrl=0 next cycle.
- Stall refresh: hold with o_ex_rt_addr=9 while WB writes r9=0x1234 -> o_ex_data_b=0x1234, all other fields unchanged.
- Zero register, macro defined: WB writes r0=0xFF while decoding rs=0 -> o_ex_data_a=0. A lw r0 followed by a use of r0 produces no stall.
